// File: rtl/crtc_sync_gen_if.sv
// Timing bus between the CRTC upcounters and the sync decoder.
// The master modport drives the counters; the slave modport (the decoder) returns the timing outputs.
interface crtc_sync_gen_if #(
  parameter int HWIDTH = 10,
  parameter int VWIDTH = 10
);
  logic              enable;
  logic [HWIDTH-1:0] hcount;
  logic [VWIDTH-1:0] vcount;
  logic              hsync;
  logic              vsync;
  logic              display_en;
  logic [HWIDTH-1:0] x;
  logic [VWIDTH-1:0] y;
  logic              line_start;
  logic              frame_start;
  logic              blink;
  logic              range_err;

  modport master (
    output enable, hcount, vcount,
    input  hsync, vsync, display_en, x, y, line_start, frame_start, blink, range_err
  );

  modport slave (
    input  enable, hcount, vcount,
    output hsync, vsync, display_en, x, y, line_start, frame_start, blink, range_err
  );
endinterface

// File: rtl/crtc_sync_gen.sv
// CRTC timing decoder: per-axis phase FSMs on sampled hcount/vcount, producing registered
// sync, display enable, pixel coordinates, line/frame strobes, cursor blink and a range error flag.
module crtc_sync_gen #(
  parameter int HWIDTH       = 10,
  parameter int VWIDTH       = 10,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0,
  parameter int BLINK_FRAMES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  crtc_sync_gen_if.slave   bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef enum logic [1:0] {ST_ACTIVE, ST_FRONT, ST_SYNC, ST_BACK} phase_e;

  phase_e h_q, h_d, v_q, v_d;

  // Full-width compares against compile-time boundaries; no wrap arithmetic.
  logic [31:0] hc, vc;
  logic        hc0, vc0, oor;

  assign hc  = 32'(bus.hcount);
  assign vc  = 32'(bus.vcount);
  assign hc0 = (hc == 32'd0);
  assign vc0 = (vc == 32'd0);
  assign oor = (hc >= 32'(H_TOTAL)) || (vc >= 32'(V_TOTAL));

  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              de_q, de_d;
  logic [HWIDTH-1:0] x_q, x_d;
  logic [VWIDTH-1:0] y_q, y_d;
  logic              ls_q, ls_d;
  logic              fs_q, fs_d;
  logic              blink_q, blink_d;
  logic              rerr_q, rerr_d;
  logic [7:0]        fcnt_q, fcnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q <= ST_ACTIVE;
      v_q <= ST_ACTIVE;
    end else if (bus.enable) begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Out-of-range samples freeze both axes; V only advances on line start.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!oor) begin
      if      (hc0)                                       h_d = ST_ACTIVE;
      else if (hc == 32'(H_ACTIVE))                       h_d = ST_FRONT;
      else if (hc == 32'(H_ACTIVE + H_FP))                h_d = ST_SYNC;
      else if (hc == 32'(H_ACTIVE + H_FP + H_SYNC))       h_d = ST_BACK;
      if (hc0) begin
        if      (vc0)                                     v_d = ST_ACTIVE;
        else if (vc == 32'(V_ACTIVE))                     v_d = ST_FRONT;
        else if (vc == 32'(V_ACTIVE + V_FP))              v_d = ST_SYNC;
        else if (vc == 32'(V_ACTIVE + V_FP + V_SYNC))     v_d = ST_BACK;
      end
    end
  end

  always_comb begin
    hsync_d = (h_d == ST_SYNC) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = (v_d == ST_SYNC) ? VSYNC_POL : ~VSYNC_POL;
    de_d    = (h_d == ST_ACTIVE) && (v_d == ST_ACTIVE);
    x_d     = de_d ? bus.hcount : x_q;
    y_d     = de_d ? bus.vcount : y_q;
    ls_d    = bus.enable && hc0;
    fs_d    = bus.enable && hc0 && vc0;
    rerr_d  = rerr_q || oor;
    blink_d = blink_q;
    fcnt_d  = fcnt_q;
    if (hc0 && vc0) begin
      if (fcnt_q == 8'(BLINK_FRAMES - 1)) begin
        fcnt_d  = 8'd0;
        blink_d = ~blink_q;
      end else begin
        fcnt_d  = fcnt_q + 8'd1;
      end
    end
  end

  // Strobes reload every clock so they drop during enable=0 gaps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      blink_q <= 1'b0;
      rerr_q  <= 1'b0;
      fcnt_q  <= 8'd0;
    end else begin
      ls_q <= ls_d;
      fs_q <= fs_d;
      if (bus.enable) begin
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
        de_q    <= de_d;
        x_q     <= x_d;
        y_q     <= y_d;
        blink_q <= blink_d;
        rerr_q  <= rerr_d;
        fcnt_q  <= fcnt_d;
      end
    end
  end

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.display_en  = de_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.line_start  = ls_q;
  assign bus.frame_start = fs_q;
  assign bus.blink       = blink_q;
  assign bus.range_err   = rerr_q;

endmodule

// File: tb/tb_crtc_sync_gen.sv
// Directed-vector bench for crtc_sync_gen: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them one enabled-or-not clock after each sample.
module tb_crtc_sync_gen;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  crtc_sync_gen_if #(.HWIDTH(10), .VWIDTH(10)) bus();

  crtc_sync_gen dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int         cyc;
    logic       hs, vs, de;
    logic [9:0] x, y;
    logic       ls, fs, bk, re;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".hsync"},       32'(bus.hsync),       32'(e.hs));
    chk({tag, ".vsync"},       32'(bus.vsync),       32'(e.vs));
    chk({tag, ".display_en"},  32'(bus.display_en),  32'(e.de));
    chk({tag, ".x"},           32'(bus.x),           32'(e.x));
    chk({tag, ".y"},           32'(bus.y),           32'(e.y));
    chk({tag, ".line_start"},  32'(bus.line_start),  32'(e.ls));
    chk({tag, ".frame_start"}, 32'(bus.frame_start), 32'(e.fs));
    chk({tag, ".blink"},       32'(bus.blink),       32'(e.bk));
    chk({tag, ".range_err"},   32'(bus.range_err),   32'(e.re));
  endtask

  task automatic chk_reset(input string tag);
    exp_t e;
    e.cyc = cyc; e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.x = '0; e.y = '0;
    e.ls = 1'b0; e.fs = 1'b0; e.bk = 1'b0; e.re = 1'b0;
    chk_all(tag, e);
  endtask

  // Monitor: compare each queued expectation at the negedge of its target cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc < cyc) chk("missed_sample", 32'(cyc), 32'(e.cyc));
        else             chk_all($sformatf("cyc%0d", e.cyc), e);
      end
    end
  end

  task automatic step(input logic en, input int hc, input int vc,
                      input logic hs, input logic vs, input logic de,
                      input int x, input int y,
                      input logic ls, input logic fs, input logic bk, input logic re);
    exp_t e;
    @(posedge clk); #1;
    bus.enable = en;
    bus.hcount = 10'(hc);
    bus.vcount = 10'(vc);
    e.cyc = cyc + 1;
    e.hs = hs; e.vs = vs; e.de = de; e.x = 10'(x); e.y = 10'(y);
    e.ls = ls; e.fs = fs; e.bk = bk; e.re = re;
    q.push_back(e);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bus.enable = 1'b0;
    bus.hcount = '0;
    bus.vcount = '0;
    #12;
    chk_reset("por");
    @(posedge clk); #1 reset_n = 1'b1;

    //   en  hc   vc    hs vs de  x    y   ls fs bk re
    step(1,  0,   0,    1, 1, 1,  0,   0,  1, 1, 0, 0);
    step(1,  1,   0,    1, 1, 1,  1,   0,  0, 0, 0, 0);
    step(0,  2,   0,    1, 1, 1,  1,   0,  0, 0, 0, 0);
    step(1,  2,   0,    1, 1, 1,  2,   0,  0, 0, 0, 0);
    step(1,  639, 5,    1, 1, 1,  639, 5,  0, 0, 0, 0);
    step(1,  640, 5,    1, 1, 0,  639, 5,  0, 0, 0, 0);
    step(1,  655, 5,    1, 1, 0,  639, 5,  0, 0, 0, 0);
    step(1,  656, 5,    0, 1, 0,  639, 5,  0, 0, 0, 0);
    step(1,  751, 5,    0, 1, 0,  639, 5,  0, 0, 0, 0);
    step(1,  752, 5,    1, 1, 0,  639, 5,  0, 0, 0, 0);
    step(1,  799, 5,    1, 1, 0,  639, 5,  0, 0, 0, 0);
    step(1,  0,   6,    1, 1, 1,  0,   6,  1, 0, 0, 0);
    step(1,  0,   479,  1, 1, 1,  0,   479,1, 0, 0, 0);
    step(1,  0,   480,  1, 1, 0,  0,   479,1, 0, 0, 0);
    step(1,  0,   490,  1, 0, 0,  0,   479,1, 0, 0, 0);
    step(1,  5,   491,  1, 0, 0,  0,   479,0, 0, 0, 0);
    step(1,  0,   491,  1, 0, 0,  0,   479,1, 0, 0, 0);
    step(1,  0,   492,  1, 1, 0,  0,   479,1, 0, 0, 0);
    step(1,  640, 100,  1, 1, 0,  0,   479,0, 0, 0, 0);
    step(1,  0,   524,  1, 1, 0,  0,   479,1, 0, 0, 0);
    step(1,  0,   0,    1, 1, 1,  0,   0,  1, 1, 0, 0);
    // frame_starts 3..15 leave blink low; the 16th toggles it
    for (int i = 0; i < 13; i++)
      step(1, 0, 0,     1, 1, 1,  0,   0,  1, 1, 0, 0);
    step(1,  0,   0,    1, 1, 1,  0,   0,  1, 1, 1, 0);
    step(1,  1,   0,    1, 1, 1,  1,   0,  0, 0, 1, 0);
    step(1,  0,   0,    1, 1, 1,  0,   0,  1, 1, 1, 0);
    step(0,  0,   0,    1, 1, 1,  0,   0,  0, 0, 1, 0);
    step(1,  3,   0,    1, 1, 1,  3,   0,  0, 0, 1, 0);
    step(1,  656, 0,    0, 1, 0,  3,   0,  0, 0, 1, 0);
    // hcount==0 with vcount out of range must not resync H out of SYNC
    step(1,  0,   600,  0, 1, 0,  3,   0,  1, 0, 1, 1);
    step(1,  800, 0,    0, 1, 0,  3,   0,  0, 0, 1, 1);
    step(1,  700, 0,    0, 1, 0,  3,   0,  0, 0, 1, 1);
    drain();

    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk_reset("midline_rst");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    step(1,  10,  0,    1, 1, 1,  10,  0,  0, 0, 0, 0);
    step(1,  0,   0,    1, 1, 1,  0,   0,  1, 1, 0, 0);
    step(1,  1,   0,    1, 1, 1,  1,   0,  0, 0, 0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
